candidate_sorter: RTL and testbench



---
 rtl/candidate_sorter.sv | 200 ++++++++++++++++++++
 tb/tb_candidate_sorter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/candidate_sorter.sv
// candidate_sorter: keeps a descending top-N list of (theta, phi, score)
// samples for the current angle-search stage and publishes it, double
// buffered, with a one-cycle sorted_rdy pulse after the stage's last sample.
// Optional macro CAND_SCORE_OUT_EN adds candidate_score_buffer, published
// alongside candidate_angle_buffer.
module candidate_sorter #(
  parameter int N       = 10,
  parameter int ANGLE_W = 12,
  parameter int SCORE_W = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stage_clear,
  input  logic [3:0]               keep_num,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [ANGLE_W-1:0]       in_theta,
  input  logic [ANGLE_W-1:0]       in_phi,
  input  logic [SCORE_W-1:0]       in_score,
  output logic                     in_ready,
  output logic [N*2*ANGLE_W-1:0]   candidate_angle_buffer,
  output logic                     sorted_rdy,
  output logic                     overrun
`ifdef CAND_SCORE_OUT_EN
  ,
  output logic [N*SCORE_W-1:0]     candidate_score_buffer
`endif
);

  localparam int KW = 4;
  localparam int SW = 2 * ANGLE_W;

  typedef enum logic [1:0] {COLLECT, DRAIN, PUBLISH} state_t;

  state_t              state_reg, state_next;
  logic [KW-1:0]       keep_reg;
  logic [KW-1:0]       keep_clamped;
  logic                accept;
  logic                publish_now;

  logic                pipe_valid_reg;
  logic [ANGLE_W-1:0]  pipe_theta_reg, pipe_phi_reg;
  logic [SCORE_W-1:0]  pipe_score_reg;

  logic [N-1:0]        w_valid_reg, w_valid_next;
  logic [ANGLE_W-1:0]  w_theta_reg [N];
  logic [ANGLE_W-1:0]  w_theta_next [N];
  logic [ANGLE_W-1:0]  w_phi_reg [N];
  logic [ANGLE_W-1:0]  w_phi_next [N];
  logic [SCORE_W-1:0]  w_score_reg [N];
  logic [SCORE_W-1:0]  w_score_next [N];

  logic [N-1:0]        in_keep, gt, ins, shift;
  logic [N*SW-1:0]     pub_angle_reg, pub_angle_next;
  logic                sorted_rdy_reg, overrun_reg;

  assign keep_clamped = (keep_num == '0)      ? KW'(1) :
                        (keep_num > KW'(N))   ? KW'(N) : keep_num;
  assign accept       = in_valid && in_ready && !stage_clear;
  assign publish_now  = (state_reg == PUBLISH) && !stage_clear;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= COLLECT;
    else     state_reg <= state_next;
  end

  // Next-state logic; stage_clear aborts any drain/publish in flight
  always_comb begin
    state_next = state_reg;
    if (stage_clear) begin
      state_next = COLLECT;
    end else begin
      case (state_reg)
        COLLECT: if (accept && in_last) state_next = DRAIN;
        DRAIN:   state_next = PUBLISH;
        PUBLISH: state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  // Output decode: samples are taken only while collecting
  always_comb begin
    in_ready = (state_reg == COLLECT) && !rst;
  end

  // Keep latch, loaded with the clamped count at each stage start
  always_ff @(posedge clk) begin
    if (rst)              keep_reg <= KW'(N);
    else if (stage_clear) keep_reg <= keep_clamped;
  end

  // Pipe register between acceptance and insertion
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg <= 1'b0;
      pipe_theta_reg <= '0;
      pipe_phi_reg   <= '0;
      pipe_score_reg <= '0;
    end else if (stage_clear) begin
      pipe_valid_reg <= 1'b0;
    end else begin
      pipe_valid_reg <= accept;
      if (accept) begin
        pipe_theta_reg <= in_theta;
        pipe_phi_reg   <= in_phi;
        pipe_score_reg <= in_score;
      end
    end
  end

  // Per-slot insertion: the list is contiguous and descending, so gt is a
  // thermometer; the first set bit takes the new entry, later ones shift down.
  // Strict compare keeps earlier equal-score samples ranked higher.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign in_keep[gi] = KW'(gi) < keep_reg;
    assign gt[gi] = in_keep[gi] &&
                    (!w_valid_reg[gi] || (pipe_score_reg > w_score_reg[gi]));
    if (gi == 0) begin : g_top
      assign ins[gi]          = pipe_valid_reg && gt[gi];
      assign shift[gi]        = 1'b0;
      assign w_valid_next[gi] = ins[gi] | w_valid_reg[gi];
      assign w_theta_next[gi] = ins[gi] ? pipe_theta_reg : w_theta_reg[gi];
      assign w_phi_next[gi]   = ins[gi] ? pipe_phi_reg   : w_phi_reg[gi];
      assign w_score_next[gi] = ins[gi] ? pipe_score_reg : w_score_reg[gi];
    end else begin : g_rest
      assign ins[gi]          = pipe_valid_reg && gt[gi] && !gt[gi-1];
      assign shift[gi]        = pipe_valid_reg && gt[gi] && gt[gi-1];
      assign w_valid_next[gi] = ins[gi] ? 1'b1 :
                                shift[gi] ? w_valid_reg[gi-1] : w_valid_reg[gi];
      assign w_theta_next[gi] = ins[gi] ? pipe_theta_reg :
                                shift[gi] ? w_theta_reg[gi-1] : w_theta_reg[gi];
      assign w_phi_next[gi]   = ins[gi] ? pipe_phi_reg :
                                shift[gi] ? w_phi_reg[gi-1] : w_phi_reg[gi];
      assign w_score_next[gi] = ins[gi] ? pipe_score_reg :
                                shift[gi] ? w_score_reg[gi-1] : w_score_reg[gi];
    end
    assign pub_angle_next[gi*SW +: SW] = (w_valid_reg[gi] && in_keep[gi]) ?
                                         {w_theta_reg[gi], w_phi_reg[gi]} : '0;
  end

  // Working list: emptied at stage start and after each publish
  always_ff @(posedge clk) begin
    if (rst || stage_clear || (state_reg == PUBLISH)) begin
      w_valid_reg <= '0;
      for (int i = 0; i < N; i++) begin
        w_theta_reg[i] <= '0;
        w_phi_reg[i]   <= '0;
        w_score_reg[i] <= '0;
      end
    end else begin
      w_valid_reg <= w_valid_next;
      for (int i = 0; i < N; i++) begin
        w_theta_reg[i] <= w_theta_next[i];
        w_phi_reg[i]   <= w_phi_next[i];
        w_score_reg[i] <= w_score_next[i];
      end
    end
  end

  // Published buffer and ready pulse; the buffer holds between publishes
  always_ff @(posedge clk) begin
    if (rst) begin
      pub_angle_reg  <= '0;
      sorted_rdy_reg <= 1'b0;
    end else begin
      sorted_rdy_reg <= publish_now;
      if (publish_now) pub_angle_reg <= pub_angle_next;
    end
  end

  // Sticky overrun flag; the rejected sample is simply not captured
  always_ff @(posedge clk) begin
    if (rst) overrun_reg <= 1'b0;
    else if (in_valid && !in_ready && !stage_clear) overrun_reg <= 1'b1;
  end

  assign candidate_angle_buffer = pub_angle_reg;
  assign sorted_rdy             = sorted_rdy_reg;
  assign overrun                = overrun_reg;

`ifdef CAND_SCORE_OUT_EN
  logic [N*SCORE_W-1:0] pub_score_reg, pub_score_next;

  for (genvar gi = 0; gi < N; gi++) begin : g_pub_score
    assign pub_score_next[gi*SCORE_W +: SCORE_W] =
      (w_valid_reg[gi] && in_keep[gi]) ? w_score_reg[gi] : '0;
  end

  // Published scores track the published angles
  always_ff @(posedge clk) begin
    if (rst)              pub_score_reg <= '0;
    else if (publish_now) pub_score_reg <= pub_score_next;
  end

  assign candidate_score_buffer = pub_score_reg;
`endif

endmodule

// File: tb/tb_candidate_sorter.sv
// Directed bench for candidate_sorter: table of per-stage vectors plus
// hand-written double-buffer, abort and overrun sequences.
module tb_candidate_sorter;

  localparam int N = 10;
  localparam int AW = 12;
  localparam int SWD = 17;
  localparam int BW = N * 2 * AW;

  logic clk = 1'b0;
  logic rst, stage_clear, in_valid, in_last, in_ready, sorted_rdy, overrun;
  logic [3:0] keep_num;
  logic [AW-1:0] in_theta, in_phi;
  logic [SWD-1:0] in_score;
  logic [BW-1:0] candidate_angle_buffer;
`ifdef CAND_SCORE_OUT_EN
  logic [N*SWD-1:0] candidate_score_buffer;
`endif

  int total = 0;
  int bad = 0;

  candidate_sorter #(.N(N), .ANGLE_W(AW), .SCORE_W(SWD)) dut (
    .clk(clk), .rst(rst), .stage_clear(stage_clear), .keep_num(keep_num),
    .in_valid(in_valid), .in_last(in_last), .in_theta(in_theta),
    .in_phi(in_phi), .in_score(in_score), .in_ready(in_ready),
    .candidate_angle_buffer(candidate_angle_buffer),
    .sorted_rdy(sorted_rdy), .overrun(overrun)
`ifdef CAND_SCORE_OUT_EN
    , .candidate_score_buffer(candidate_score_buffer)
`endif
  );

  always #5 clk = ~clk;

  // exp_idx: 1-based sample index expected in each slot, 0 = empty slot
  typedef struct packed {
    logic [3:0]             keep;
    logic [3:0]             n;
    logic [0:11][SWD-1:0]   score;
    logic [0:9][3:0]        exp_idx;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Sample i carries theta i+1 and phi 0xF00|i, so each slot identifies its sample
  function automatic logic [23:0] slot_val(input int idx);
    return {12'(idx), 12'hF00 | 12'(idx - 1)};
  endfunction

  function automatic logic [BW-1:0] vec_buf(input vec_t v);
    logic [BW-1:0] b = '0;
    for (int k = 0; k < N; k++)
      if (v.exp_idx[k] != 0) b[k*24 +: 24] = slot_val(int'(v.exp_idx[k]));
    return b;
  endfunction

  task automatic stage_start(input logic [3:0] k);
    stage_clear = 1'b1;
    keep_num = k;
    tick();
    stage_clear = 1'b0;
  endtask

  task automatic send(input int i, input logic [SWD-1:0] s, input logic last);
    in_valid = 1'b1;
    in_last = last;
    in_theta = 12'(i + 1);
    in_phi = 12'hF00 | 12'(i);
    in_score = s;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Called right after the last sample's accepting edge E
  task automatic publish_check(input string name, input logic [BW-1:0] old_b, input logic [BW-1:0] new_b);
    chk({name, "_hold0"}, {sorted_rdy, candidate_angle_buffer}, {1'b0, old_b});
    tick();
    chk({name, "_hold1"}, {sorted_rdy, candidate_angle_buffer}, {1'b0, old_b});
    tick();
    chk({name, "_pub"}, {sorted_rdy, candidate_angle_buffer}, {1'b1, new_b});
    tick();
    chk({name, "_pulse_end"}, {sorted_rdy, in_ready}, 2'b01);
  endtask

  initial begin
    logic [BW-1:0] prev_b, exp_b;

    vecs[0] = '{keep:4'd3, n:4'd4,
                score:'{17'd5, 17'd9, 17'd2, 17'd7, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0},
                exp_idx:'{4'd2, 4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[1] = '{keep:4'd2, n:4'd3,
                score:'{17'd8, 17'd8, 17'd8, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0},
                exp_idx:'{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[2] = '{keep:4'd0, n:4'd4,
                score:'{17'd3, 17'd11, 17'd6, 17'd4, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0},
                exp_idx:'{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[3] = '{keep:4'd15, n:4'd12,
                score:'{17'd40, 17'd10, 17'd70, 17'd20, 17'd110, 17'd90, 17'd30, 17'd120, 17'd60, 17'd50, 17'd100, 17'd80},
                exp_idx:'{4'd8, 4'd5, 4'd11, 4'd6, 4'd12, 4'd3, 4'd9, 4'd10, 4'd1, 4'd7}};
    vecs[4] = '{keep:4'd1, n:4'd1,
                score:'{17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0},
                exp_idx:'{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[5] = '{keep:4'd4, n:4'd5,
                score:'{17'h1FFFF, 17'd0, 17'h10000, 17'h1FFFF, 17'd5, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0},
                exp_idx:'{4'd1, 4'd4, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[6] = '{keep:4'd2, n:4'd3,
                score:'{17'd9, 17'd8, 17'd7, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0},
                exp_idx:'{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[7] = '{keep:4'd3, n:4'd4,
                score:'{17'd1, 17'd2, 17'd3, 17'd4, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0},
                exp_idx:'{4'd4, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};

    rst = 1'b1; stage_clear = 1'b0; keep_num = 4'd0; in_valid = 1'b0; in_last = 1'b0;
    in_theta = '0; in_phi = '0; in_score = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", {sorted_rdy, overrun, candidate_angle_buffer}, '0);
    chk("reset_ready", {31'd0, in_ready}, 1);

    // Table-driven stages
    prev_b = '0;
    for (int v = 0; v < 8; v++) begin
      stage_start(vecs[v].keep);
      for (int i = 0; i < int'(vecs[v].n); i++)
        send(i, vecs[v].score[i], i == int'(vecs[v].n) - 1);
      exp_b = vec_buf(vecs[v]);
      publish_check($sformatf("vec%0d", v), prev_b, exp_b);
      $display("txn vec%0d keep=%0d n=%0d buf=%h", v, vecs[v].keep, vecs[v].n, candidate_angle_buffer);
      prev_b = exp_b;
    end

    // Double buffer: list A stays while 50 samples of the next stage stream in
    stage_start(4'd10);
    for (int i = 0; i < 50; i++) begin
      send(i, 17'(i), 1'b0);
      chk("dbuf_hold", {sorted_rdy, candidate_angle_buffer}, {1'b0, prev_b});
    end
    send(50, 17'd1000, 1'b1);
    exp_b = '0;
    for (int k = 0; k < N; k++) exp_b[k*24 +: 24] = slot_val(51 - k);
    publish_check("dbuf", prev_b, exp_b);
    $display("txn dbuf buf=%h", candidate_angle_buffer);
    prev_b = exp_b;

    // Abort during DRAIN: no publish, then a fresh keep=2 stage
    stage_start(4'd3);
    send(0, 17'd5, 1'b0);
    send(1, 17'd9, 1'b1);
    stage_clear = 1'b1; keep_num = 4'd2;
    tick();
    stage_clear = 1'b0;
    chk("abort_ready", {sorted_rdy, in_ready}, 2'b01);
    tick();
    chk("abort_hold1", {sorted_rdy, candidate_angle_buffer}, {1'b0, prev_b});
    tick();
    chk("abort_hold2", {sorted_rdy, candidate_angle_buffer}, {1'b0, prev_b});
    send(0, 17'd4, 1'b0);
    send(1, 17'd6, 1'b1);
    exp_b = '0;
    exp_b[23:0] = slot_val(2);
    exp_b[47:24] = slot_val(1);
    publish_check("abort_fresh", prev_b, exp_b);
    $display("txn abort buf=%h", candidate_angle_buffer);
    prev_b = exp_b;

    // Overrun: in_valid kept high through DRAIN and PUBLISH
    stage_start(4'd3);
    chk("overrun_clear", {31'd0, overrun}, 0);
    in_valid = 1'b1; in_last = 1'b1; in_theta = 12'd1; in_phi = 12'hF00; in_score = 17'd5;
    tick();
    in_last = 1'b0; in_theta = 12'd77; in_phi = 12'd77; in_score = 17'd100;
    tick();
    chk("overrun_set", {31'd0, overrun}, 1);
    tick();
    exp_b = '0;
    exp_b[23:0] = slot_val(1);
    chk("overrun_pub", {sorted_rdy, candidate_angle_buffer}, {1'b1, exp_b});
    in_valid = 1'b0;
    tick();
    stage_start(4'd3);
    send(1, 17'd3, 1'b1);
    prev_b = exp_b;
    exp_b = '0;
    exp_b[23:0] = slot_val(2);
    publish_check("overrun_next", prev_b, exp_b);
    chk("overrun_sticky", {31'd0, overrun}, 1);
    $display("txn overrun buf=%h", candidate_angle_buffer);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_clears", {sorted_rdy, overrun, candidate_angle_buffer}, '0);
    chk("rst_ready", {31'd0, in_ready}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
